uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/uart_rx_fifo.sv | 88 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive buffer: capture FSM states and FIFO entry layout.
// An entry is {overwritten, parity_error, data}; flag positions are offsets above the data field.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STORE    = 2'd1,
    ST_ACK      = 2'd2,
    ST_WAIT_LOW = 2'd3
  } cap_state_e;

  localparam int FLAG_W  = 2;
  localparam int PAR_OFS = 0;
  localparam int OVW_OFS = 1;

  function automatic int entry_width(input int data_len);
    return data_len + FLAG_W;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head visible combinationally, push/pop take effect at the edge.
// A push while full is accepted only when a pop happens in the same cycle; pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

  // A full FIFO is never empty, so a coincident pop always frees the slot being written.
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_wr && !do_rd)      count_d = count_q + CW'(1);
    else if (do_rd && !do_wr) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Captures UART receiver words into a FIFO via a ready/acknowledge handshake; write one edge after ready seen.
// When full the word is dropped (sticky overflow) but still acknowledged, so the receiver never stalls.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_LEN = 8,
  parameter int DEPTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_LEN-1:0]    rx_data,
  input  logic                   rx_data_ready,
  input  logic                   rx_parity_error,
  input  logic                   rx_overwritten,
  output logic                   rx_data_readed,
  input  logic                   rd_en,
  output logic [DATA_LEN-1:0]    rd_data,
  output logic                   rd_parity_error,
  output logic                   rd_overwritten,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  localparam int EW = entry_width(DATA_LEN);

  cap_state_e      state_q;
  logic            readed_q;
  logic            overflow_q;
  logic            fifo_wr;
  logic            drop;
  logic [EW-1:0]   wr_entry;
  logic [EW-1:0]   rd_entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      readed_q <= 1'b0;
    end else begin
      readed_q <= 1'b0;
      case (state_q)
        ST_IDLE:     if (rx_data_ready) state_q <= ST_STORE;
        ST_STORE: begin
          state_q  <= ST_ACK;
          readed_q <= 1'b1;
        end
        ST_ACK:      state_q <= ST_WAIT_LOW;
        ST_WAIT_LOW: if (!rx_data_ready) state_q <= ST_IDLE;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

  // Gating with rst keeps a reset during STORE from leaving a half-committed word.
  assign fifo_wr  = (state_q == ST_STORE) && !rst;
  assign drop     = fifo_wr && full && !rd_en;
  assign wr_entry = {rx_overwritten, rx_parity_error, rx_data};

  always_ff @(posedge clk) begin
    if (rst)               overflow_q <= 1'b0;
    else if (drop)         overflow_q <= 1'b1;
    else if (clr_overflow) overflow_q <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (fifo_wr),
    .wr_data_i (wr_entry),
    .rd_en_i   (rd_en),
    .rd_data_o (rd_entry),
    .empty_o   (empty),
    .full_o    (full),
    .count_o   (count)
  );

  assign rd_data         = rd_entry[DATA_LEN-1:0];
  assign rd_parity_error = rd_entry[DATA_LEN+PAR_OFS];
  assign rd_overwritten  = rd_entry[DATA_LEN+OVW_OFS];
  assign rx_data_readed  = readed_q;
  assign overflow        = overflow_q;

endmodule
